// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the word serializer.
// The bit counter is sized to index one word of WIDTH bits.
package serializer_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial front end: valid/ready word input, MSB-first serial output.
// A one-word holding buffer lets consecutive words stream with no idle bit between them.
module word_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             en,
  output logic             data_out,
  output logic             out_valid,
  output logic             word_start,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             hold_full_q, hold_full_d;

  logic             accept;
  logic             last_consumed;

  assign in_ready      = !hold_full_q;
  assign accept        = in_valid && in_ready;
  assign last_consumed = (state_q == S_SHIFT) && en && (bitcnt_q == LAST_BIT);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          shreg_d  = in_data;
          bitcnt_d = '0;
          state_d  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (last_consumed) begin
          // Buffered word wins; a direct load is only possible when the buffer is empty.
          if (hold_full_q) begin
            shreg_d     = hold_data_q;
            hold_full_d = 1'b0;
            bitcnt_d    = '0;
          end else if (accept) begin
            shreg_d  = in_data;
            bitcnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          if (en) begin
            shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
            bitcnt_d = bitcnt_q + CW'(1);
          end
          if (accept) begin
            hold_data_d = in_data;
            hold_full_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
    end
  end

  // Outputs decode purely from registered state.
  assign out_valid  = (state_q == S_SHIFT);
  assign data_out   = out_valid & shreg_q[WIDTH-1];
  assign word_start = out_valid & (bitcnt_q == '0);
  assign busy       = out_valid | hold_full_q;

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: accepted words become an expected bit stream,
// a negedge monitor consumes it and compares every output.
module tb_word_serializer;

  localparam int WIDTH = 10;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             en;
  logic             data_out;
  logic             out_valid;
  logic             word_start;
  logic             busy;

  word_serializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .en         (en),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .word_start (word_start),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit b;
    bit first;
  } exp_bit_t;

  exp_bit_t exp_q[$];
  int       n_vec = 0;
  int       n_err = 0;
  bit       exp_ready = 1'b1;
  bit       acc_evt = 1'b0;
  int       ones_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int words_pending();
    return (exp_q.size() + WIDTH - 1) / WIDTH;
  endfunction

  // Reference: every accepted word appends its bits MSB first to the expected stream.
  always @(posedge clk) begin
    acc_evt = 1'b0;
    if (reset_n && in_valid && exp_ready) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        exp_bit_t e;
        e.b     = in_data[i];
        e.first = (i == WIDTH - 1);
        exp_q.push_back(e);
      end
      acc_evt = 1'b1;
    end
  end

  always @(negedge reset_n) begin
    exp_q.delete();
    exp_ready = 1'b1;
  end

  // Monitor: outputs must reflect the head of the expected stream; an enabled cycle consumes one bit.
  always @(negedge clk) begin
    bit ev;
    ev        = (exp_q.size() > 0);
    exp_ready = (words_pending() < 2);
    chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
    chk("busy", {31'd0, busy}, {31'd0, ev});
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    chk("data_out", {31'd0, data_out}, {31'd0, ev ? exp_q[0].b : 1'b0});
    chk("word_start", {31'd0, word_start}, {31'd0, ev ? exp_q[0].first : 1'b0});
    if (reset_n && en && ev) begin
      if (exp_q[0].b) ones_cnt++;
      void'(exp_q.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds in_valid until the model sees the word accepted; leaves in_valid high.
  task automatic send_word(input logic [WIDTH-1:0] w);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #1;
      done = acc_evt;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_word timeout: got no accept expected accept of %0h", w);
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() > 0 && i < 300) begin
      cyc(1);
      i++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain timeout: got %0d bits left expected 0", exp_q.size());
    end
    cyc(2);
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    en       = 1'b1;
    cyc(2);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst data_out", {31'd0, data_out}, 32'd0);
    chk("rst word_start", {31'd0, word_start}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    reset_n = 1'b1;

    // Idle hold
    cyc(20);

    // Single word plus downstream ones count
    ones_cnt = 0;
    w = 10'b1011001110;
    send_word(w);
    in_valid = 1'b0;
    drain();
    chk("single ones", ones_cnt, $countones(w));

    // Back-to-back with holding buffer full
    send_word(10'h3FF);
    send_word(10'h000);
    send_word(10'h155);
    in_valid = 1'b0;
    drain();

    // Enable stall at bit 4
    send_word(10'h2AA);
    in_valid = 1'b0;
    cyc(4);
    en = 1'b0;
    cyc(3);
    en = 1'b1;
    drain();

    // Accept exactly in the last-bit cycle with empty buffer
    send_word(10'h1C3);
    in_valid = 1'b0;
    cyc(9);
    chk("lastbit in_ready", {31'd0, in_ready}, 32'd1);
    send_word(10'h2F0);
    in_valid = 1'b0;
    drain();

    // Reset mid-word with holding buffer full
    send_word(10'h3A5);
    send_word(10'h0F0);
    in_valid = 1'b0;
    cyc(4);
    reset_n = 1'b0;
    #1;
    chk("mrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst data_out", {31'd0, data_out}, 32'd0);
    chk("mrst word_start", {31'd0, word_start}, 32'd0);
    chk("mrst busy", {31'd0, busy}, 32'd0);
    chk("mrst in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = 10'h3FF;
    cyc(3);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    cyc(6);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      in_valid = ($urandom_range(0, 99) < 45);
      in_data  = WIDTH'($urandom);
      en       = ($urandom_range(0, 99) < 80);
      cyc(1);
    end
    in_valid = 1'b0;
    en       = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
